// File: rtl/i2c_mem_arbiter.sv
// Purpose : shares one single-port synchronous memory between NUM_PORTS requesters (round-robin, optional per-port lock).
// Latency : grant and memory strobe 1 cycle after the sampled request; read data RD_LATENCY cycles after the strobe.
// Backpressure: requesters hold in_req until their out_gnt pulse; a port's request is masked while its out_gnt is high.
// Optional feature: define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module i2c_mem_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MEM_DATA_WIDTH = 8,
    parameter int RD_LATENCY     = 1,
    parameter int MAX_BURST      = 16
) (
    input  logic                                in_clk,
    input  logic                                in_rst,
    input  logic [NUM_PORTS-1:0]                in_req,
    input  logic [NUM_PORTS-1:0]                in_lock,
    input  logic [NUM_PORTS-1:0]                in_we,
    input  logic [NUM_PORTS*MEM_ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_PORTS*MEM_DATA_WIDTH-1:0] in_wdata,
    output logic [NUM_PORTS-1:0]                out_gnt,
    output logic [NUM_PORTS-1:0]                out_rvalid,
    output logic [MEM_DATA_WIDTH-1:0]           out_rdata,
    output logic                                out_mem_en,
    output logic                                out_mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]           out_mem_addr,
    output logic [MEM_DATA_WIDTH-1:0]           out_mem_wdata,
    input  logic [MEM_DATA_WIDTH-1:0]           in_mem_rdata
);

    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = MEM_DATA_WIDTH;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ARB   = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    arb_state_t           state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [BW-1:0]        burst_q, burst_d;

    logic [NUM_PORTS-1:0] eff_req;
    logic [NUM_PORTS-1:0] cand;
    logic                 win_vld;
    logic [PW-1:0]        win_id;
    int                   scan_idx;
    logic [NUM_PORTS-1:0] gnt_d;

    // Port id of the access currently on the memory bus, tagged into the read pipe.
    logic [PW-1:0]        cur_id_q;

    // Read-return pipe: one slot per cycle of memory latency.
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [PW-1:0]         pipe_id_q [RD_LATENCY];

    // Pointer value that starts the next scan just past the given port.
    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] id);
        return (int'(id) == NUM_PORTS - 1) ? '0 : id + 1'b1;
    endfunction

    // A port that is being granted this cycle must not be granted again from the same held request.
    assign eff_req = in_req & ~out_gnt;

    // Winner selection and ownership/burst next-state logic.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        burst_d  = burst_q;
        cand     = '0;
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = 0;
        gnt_d    = '0;

        if (state_q == OWNED) begin
            cand[owner_q] = eff_req[owner_q];
        end else begin
            cand = eff_req;
        end

        for (int n = 0; n < NUM_PORTS; n++) begin
            scan_idx = (int'(rr_q) + n) % NUM_PORTS;
            if (!win_vld && cand[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = PW'(scan_idx);
            end
        end

        if (win_vld) begin
            gnt_d[win_id] = 1'b1;
        end

        case (state_q)
            ARB: begin
                if (win_vld) begin
                    // A burst limit of one means the lock can never extend ownership.
                    if (in_lock[win_id] && (MAX_BURST > 1)) begin
                        state_d = OWNED;
                        owner_d = win_id;
                        burst_d = BW'(1);
                    end else begin
                        rr_d = ptr_after(win_id);
                    end
                end
            end
            OWNED: begin
                // Lock drop or burst exhaustion both hand the bus back; the current grant still issues.
                if (!in_lock[owner_q] || (win_vld && (int'(burst_q) + 1 >= MAX_BURST))) begin
                    state_d = ARB;
                    rr_d    = ptr_after(owner_q);
                    burst_d = '0;
                end else if (win_vld) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ARB;
            owner_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
`ifdef MEM_ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`else
            rr_q    <= rr_d;
`endif
        end
    end

    // Registered grant and memory command; address/data hold when idle.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_gnt       <= '0;
            out_mem_en    <= 1'b0;
            out_mem_we    <= 1'b0;
            out_mem_addr  <= '0;
            out_mem_wdata <= '0;
            cur_id_q      <= '0;
        end else begin
            out_gnt    <= gnt_d;
            out_mem_en <= win_vld;
            out_mem_we <= win_vld && in_we[win_id];
            if (win_vld) begin
                out_mem_addr  <= in_addr[int'(win_id)*AW +: AW];
                out_mem_wdata <= in_wdata[int'(win_id)*DW +: DW];
                cur_id_q      <= win_id;
            end
        end
    end

    // Read owner shift register; reset drops every read still in flight.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_id_q[i] <= '0;
            end
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
            pipe_vld_q[0] <= out_mem_en && !out_mem_we;
            pipe_id_q[0]  <= cur_id_q;
        end
    end

    // Route the returning memory data to the port that issued the read.
    always_comb begin
        out_rvalid = '0;
        if (pipe_vld_q[RD_LATENCY-1]) begin
            out_rvalid[pipe_id_q[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign out_rdata = in_mem_rdata;

endmodule
